// File: rtl/execute_stage.sv
// Y86-64 execute stage: computes valE, evaluates cmov/jump conditions and maintains the
// condition-code register, with a one-deep registered output and valid/ready handshake.
module execute_stage #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned STACK_STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  input  logic             set_cc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] valE,
  output logic             cnd,
  output logic [2:0]       cc,
  output logic             err
);

  if (WIDTH < 8) begin : g_width_check
    $error("execute_stage: WIDTH must be at least 8");
  end

  localparam int unsigned     Msb  = WIDTH - 1;
  localparam logic [WIDTH-1:0] Step = WIDTH'(STACK_STEP);

  localparam logic [3:0] ICmov  = 4'd2;
  localparam logic [3:0] IIrmov = 4'd3;
  localparam logic [3:0] IRmmov = 4'd4;
  localparam logic [3:0] IMrmov = 4'd5;
  localparam logic [3:0] IOpq   = 4'd6;
  localparam logic [3:0] IJxx   = 4'd7;
  localparam logic [3:0] ICall  = 4'd8;
  localparam logic [3:0] IRet   = 4'd9;
  localparam logic [3:0] IPush  = 4'd10;
  localparam logic [3:0] IPop   = 4'd11;

  localparam logic [2:0] CcReset = 3'b100;

  logic             accept;
  logic             zf, sf, of;
  logic [WIDTH-1:0] alu_res;
  logic             alu_of;
  logic             cond_true;
  logic             cond_ifun_ok;
  logic             op_ifun_ok;
  logic [WIDTH-1:0] vale_d;
  logic             cnd_d;
  logic             err_d;
  logic             cc_we;
  logic [2:0]       cc_d;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  assign {zf, sf, of} = cc;

  assign cond_ifun_ok = (ifun <= 4'd6);
  assign op_ifun_ok   = (ifun <= 4'd3);

  // ALU for OPq; decoded on the low bits, out-of-range ifun is caught by op_ifun_ok.
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    unique case (ifun[1:0])
      2'd0: begin
        alu_res = valB + valA;
        alu_of  = (valA[Msb] == valB[Msb]) & (alu_res[Msb] != valB[Msb]);
      end
      2'd1: begin
        alu_res = valB - valA;
        alu_of  = (valA[Msb] != valB[Msb]) & (alu_res[Msb] != valB[Msb]);
      end
      2'd2: alu_res = valB & valA;
      2'd3: alu_res = valB ^ valA;
    endcase
  end

  assign cc_d = {(alu_res == '0), alu_res[Msb], alu_of};

  // Conditions read the current CC register, i.e. the value before this edge's update.
  always_comb begin
    cond_true = 1'b0;
    case (ifun)
      4'd0:    cond_true = 1'b1;
      4'd1:    cond_true = (sf ^ of) | zf;
      4'd2:    cond_true = sf ^ of;
      4'd3:    cond_true = zf;
      4'd4:    cond_true = !zf;
      4'd5:    cond_true = !(sf ^ of);
      4'd6:    cond_true = !(sf ^ of) & !zf;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    vale_d = '0;
    cnd_d  = 1'b0;
    err_d  = 1'b0;
    cc_we  = 1'b0;
    case (icode)
      ICmov: begin
        if (cond_ifun_ok) begin
          vale_d = valA;
          cnd_d  = cond_true;
        end else begin
          err_d = 1'b1;
        end
      end
      IJxx: begin
        if (cond_ifun_ok) begin
          cnd_d = cond_true;
        end else begin
          err_d = 1'b1;
        end
      end
      IIrmov:         vale_d = valC;
      IRmmov, IMrmov: vale_d = valB + valC;
      IOpq: begin
        if (op_ifun_ok) begin
          vale_d = alu_res;
          cc_we  = set_cc_en;
        end else begin
          err_d = 1'b1;
        end
      end
      ICall, IPush:   vale_d = valB - Step;
      IRet, IPop:     vale_d = valB + Step;
      default:        vale_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      valE      <= '0;
      cnd       <= 1'b0;
      err       <= 1'b0;
      cc        <= CcReset;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        valE      <= vale_d;
        cnd       <= cnd_d;
        err       <= err_d;
        if (cc_we) begin
          cc <= cc_d;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, handshake/reset sequences, a 16-bit
// instance, and randomized traffic checked against a behavioural model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  icode, ifun;
  logic [63:0] valA, valB, valC, valE;
  logic        set_cc_en, cnd, err;
  logic [2:0]  cc;

  logic        iv16, ir16, ov16, cnd16, err16;
  logic [3:0]  ic16, fn16;
  logic [15:0] a16, b16, c16, e16;
  logic [2:0]  cc16;

  always #5 clk = ~clk;

  execute_stage #(.WIDTH(64), .STACK_STEP(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .icode(icode),
    .ifun(ifun), .valA(valA), .valB(valB), .valC(valC), .set_cc_en(set_cc_en),
    .out_valid(out_valid), .out_ready(out_ready), .valE(valE), .cnd(cnd), .cc(cc), .err(err)
  );

  execute_stage #(.WIDTH(16), .STACK_STEP(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .icode(ic16),
    .ifun(fn16), .valA(a16), .valB(b16), .valC(c16), .set_cc_en(1'b1),
    .out_valid(ov16), .out_ready(1'b1), .valE(e16), .cnd(cnd16), .cc(cc16), .err(err16)
  );

  int total = 0;
  int bad   = 0;

  task automatic chkv(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkc(input string name, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: signed-overflow via a widened sum, flags as {ZF,SF,OF}.
  typedef struct packed {
    logic [63:0] v;
    logic        c;
    logic        e;
    logic [2:0]  cc;
  } res_t;

  function automatic res_t model(input logic [3:0] ic, input logic [3:0] fn,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] c, input logic sce, input logic [2:0] ccin);
    res_t r;
    logic signed [64:0] w;
    logic zf, sf, of, lt;
    r = '0;
    r.cc = ccin;
    zf = ccin[2];
    sf = ccin[1];
    of = ccin[0];
    lt = (sf != of);
    w = '0;
    case (ic)
      4'd2, 4'd7: begin
        if (fn > 4'd6) r.e = 1'b1;
        else begin
          case (fn)
            4'd0: r.c = 1'b1;
            4'd1: r.c = lt || zf;
            4'd2: r.c = lt;
            4'd3: r.c = zf;
            4'd4: r.c = !zf;
            4'd5: r.c = !lt;
            default: r.c = !lt && !zf;
          endcase
          if (ic == 4'd2) r.v = a;
        end
      end
      4'd3: r.v = c;
      4'd4, 4'd5: r.v = b + c;
      4'd8, 4'd10: r.v = b - 64'd8;
      4'd9, 4'd11: r.v = b + 64'd8;
      4'd6: begin
        if (fn > 4'd3) r.e = 1'b1;
        else begin
          case (fn)
            4'd0: w = $signed({b[63], b}) + $signed({a[63], a});
            4'd1: w = $signed({b[63], b}) - $signed({a[63], a});
            4'd2: w = $signed({1'b0, b & a});
            default: w = $signed({1'b0, b ^ a});
          endcase
          r.v = w[63:0];
          of = (fn < 4'd2) && (w[64] != w[63]);
          if (sce) r.cc = {(r.v == 64'd0), r.v[63], of};
        end
      end
      default: r.v = 64'd0;
    endcase
    return r;
  endfunction

  typedef struct {
    logic [3:0]  ic;
    logic [3:0]  fn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic        sce;
    logic [63:0] ev;
    logic        ec;
    logic        ee;
    logic [2:0]  ecc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'h7fff_ffff_ffff_ffff;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'hffff_ffff_ffff_ffff;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic sce);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c; set_cc_en = sce;
  endtask

  logic [63:0] held_v;
  logic [2:0]  held_cc;
  res_t        r;
  logic        acc;
  logic        m_ov, m_c, m_e;
  logic [63:0] m_v;
  logic [2:0]  m_cc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(4'd0, 4'd0, 64'd0, 64'd0, 64'd0, 1'b1);
    iv16 = 1'b0; ic16 = 4'd0; fn16 = 4'd0; a16 = 16'd0; b16 = 16'd0; c16 = 16'd0;

    // {icode, ifun, valA, valB, valC, set_cc_en, valE, cnd, err, cc}
    tbl.push_back('{4'd6, 4'd1, 64'd5, 64'd5, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 3'b100});
    tbl.push_back('{4'd7, 4'd3, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, 3'b100});
    tbl.push_back('{4'd7, 4'd4, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 3'b100});
    tbl.push_back('{4'd6, 4'd0, 64'd1, 64'h7fff_ffff_ffff_ffff, 64'd0, 1'b1,
                    64'h8000_0000_0000_0000, 1'b0, 1'b0, 3'b011});
    tbl.push_back('{4'd2, 4'd2, 64'h55, 64'd0, 64'd0, 1'b1, 64'h55, 1'b0, 1'b0, 3'b011});
    tbl.push_back('{4'd10, 4'd0, 64'd0, 64'h100, 64'd0, 1'b1, 64'hf8, 1'b0, 1'b0, 3'b011});
    tbl.push_back('{4'd11, 4'd0, 64'd0, 64'hf8, 64'd0, 1'b1, 64'h100, 1'b0, 1'b0, 3'b011});
    tbl.push_back('{4'd6, 4'd7, 64'd1, 64'd2, 64'd0, 1'b1, 64'd0, 1'b0, 1'b1, 3'b011});
    tbl.push_back('{4'd6, 4'd0, 64'd3, 64'd4, 64'd0, 1'b0, 64'd7, 1'b0, 1'b0, 3'b011});
    tbl.push_back('{4'd6, 4'd2, 64'hf0, 64'h0f, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 3'b100});
    tbl.push_back('{4'd7, 4'd1, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, 3'b100});
    tbl.push_back('{4'd6, 4'd1, 64'd1, 64'd0, 64'd0, 1'b1, 64'hffff_ffff_ffff_ffff,
                    1'b0, 1'b0, 3'b010});
    tbl.push_back('{4'd7, 4'd2, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, 3'b010});
    tbl.push_back('{4'd7, 4'd6, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 3'b010});
    tbl.push_back('{4'd7, 4'd5, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 3'b010});
    tbl.push_back('{4'd7, 4'd7, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0, 1'b1, 3'b010});
    tbl.push_back('{4'd2, 4'd0, 64'h1234, 64'd0, 64'd0, 1'b1, 64'h1234, 1'b1, 1'b0, 3'b010});
    tbl.push_back('{4'd3, 4'd0, 64'd0, 64'd0, 64'hdead, 1'b1, 64'hdead, 1'b0, 1'b0, 3'b010});
    tbl.push_back('{4'd4, 4'd0, 64'd0, 64'h10, 64'h8, 1'b1, 64'h18, 1'b0, 1'b0, 3'b010});
    tbl.push_back('{4'd5, 4'd0, 64'd0, 64'hffff_ffff_ffff_ffff, 64'd2, 1'b1, 64'd1,
                    1'b0, 1'b0, 3'b010});
    tbl.push_back('{4'd8, 4'd0, 64'd0, 64'd0, 64'd0, 1'b1, 64'hffff_ffff_ffff_fff8,
                    1'b0, 1'b0, 3'b010});
    tbl.push_back('{4'd9, 4'd0, 64'd0, 64'hffff_ffff_ffff_fff8, 64'd0, 1'b1, 64'd0,
                    1'b0, 1'b0, 3'b010});
    tbl.push_back('{4'd0, 4'd0, 64'd5, 64'd5, 64'd5, 1'b1, 64'd0, 1'b0, 1'b0, 3'b010});
    tbl.push_back('{4'd6, 4'd3, 64'hff, 64'hff, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 3'b100});
    tbl.push_back('{4'd6, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b1,
                    64'h7fff_ffff_ffff_ffff, 1'b0, 1'b0, 3'b001});
    tbl.push_back('{4'd7, 4'd2, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, 3'b001});

    // Reset and idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset out_valid", out_valid, 1'b0);
    chkc("reset cc", cc, 3'b100);
    chkv("reset valE", valE, 64'd0);
    chk1("reset in_ready", in_ready, 1'b1);

    // Directed vectors, back to back
    foreach (tbl[i]) begin
      drive(tbl[i].ic, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].sce);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk1($sformatf("vec%0d out_valid", i), out_valid, 1'b1);
      chkv($sformatf("vec%0d valE", i), valE, tbl[i].ev);
      chk1($sformatf("vec%0d cnd", i), cnd, tbl[i].ec);
      chk1($sformatf("vec%0d err", i), err, tbl[i].ee);
      chkc($sformatf("vec%0d cc", i), cc, tbl[i].ecc);
    end
    held_v  = tbl[tbl.size()-1].ev;
    held_cc = tbl[tbl.size()-1].ecc;

    // Backpressure: new OPq waits while the result is held
    out_ready = 1'b0;
    drive(4'd6, 4'd0, 64'd1, 64'd1, 64'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk1("stall in_ready", in_ready, 1'b0);
      chk1("stall out_valid", out_valid, 1'b1);
      chkv("stall valE", valE, held_v);
      chkc("stall cc", cc, held_cc);
    end
    out_ready = 1'b1;
    #1 chk1("release in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    chkv("release valE", valE, 64'd2);
    chkc("release cc", cc, 3'b000);
    chk1("release out_valid", out_valid, 1'b1);

    // Asynchronous reset while a result is held
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk1("async rst out_valid", out_valid, 1'b0);
    chkc("async rst cc", cc, 3'b100);
    chkv("async rst valE", valE, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;

    // 16-bit instance: flags come from bit 15
    iv16 = 1'b1; ic16 = 4'd6; fn16 = 4'd1; a16 = 16'd5; b16 = 16'd5;
    @(posedge clk);
    #1;
    chkv("w16 sub valE", 64'(e16), 64'd0);
    chkc("w16 sub cc", cc16, 3'b100);
    a16 = 16'd1; b16 = 16'h8000;
    @(posedge clk);
    #1;
    chkv("w16 ovf valE", 64'(e16), 64'h7fff);
    chkc("w16 ovf cc", cc16, 3'b001);
    ic16 = 4'd7; fn16 = 4'd2;
    @(posedge clk);
    #1;
    chk1("w16 jl cnd", cnd16, 1'b1);
    ic16 = 4'd10; fn16 = 4'd0; b16 = 16'd4;
    @(posedge clk);
    #1;
    chkv("w16 push wrap", 64'(e16), 64'hfffc);
    chk1("w16 err", err16, 1'b0);
    chk1("w16 out_valid", ov16, 1'b1);
    chk1("w16 in_ready", ir16, 1'b1);
    iv16 = 1'b0;

    // Randomized traffic against the model, starting from a fresh reset
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_ov = 1'b0; m_v = 64'd0; m_c = 1'b0; m_e = 1'b0; m_cc = 3'b100;
    for (int n = 0; n < 1500; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive(4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6)),
            rnd_op(), rnd_op(), rnd_op(), ($urandom_range(0, 3) != 0));
      #1;
      chk1("rnd in_ready", in_ready, !m_ov || out_ready);
      acc = in_valid && (!m_ov || out_ready);
      r = model(icode, ifun, valA, valB, valC, set_cc_en, m_cc);
      @(posedge clk);
      #1;
      if (acc) begin
        m_ov = 1'b1; m_v = r.v; m_c = r.c; m_e = r.e; m_cc = r.cc;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      chk1("rnd out_valid", out_valid, m_ov);
      chkv("rnd valE", valE, m_v);
      chk1("rnd cnd", cnd, m_c);
      chk1("rnd err", err, m_e);
      chkc("rnd cc", cc, m_cc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Parametrised, registered execute stage for the Y86-64 processor. It sits between decode and memory.
- Computes valE, evaluates the branch/cmov condition from a persistent condition-code register, and updates CC on OPq.
- Results are held in a one-deep output register with a valid/ready handshake, so the stage can be stalled by downstream.

Parameters:
- WIDTH, 64, datapath width of valA/valB/valC/valE. Must be ≥ 8; elaboration error otherwise.
- STACK_STEP, 8, increment/decrement applied to valB for call/ret/pushq/popq, zero-extended to WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  decode presents a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- icode  input  4  instruction code.
- ifun  input  4  function code.
- valA  input  WIDTH  operand A.
- valB  input  WIDTH  operand B.
- valC  input  WIDTH  constant.
- set_cc_en  input  1  when 0, an accepted OPq does not write CC (used for squash).
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  downstream consumes the result.
- valE  output  WIDTH  execute result.
- cnd  output  1  condition outcome for cmovXX/jXX.
- cc  output  3  {ZF,SF,OF} current CC register.
- err  output  1  invalid ifun for the accepted instruction.

Behaviour:

Reset:
- out_valid=0, valE=0, cnd=0, err=0, cc={ZF=1,SF=0,OF=0}.
- Reset is asynchronous and takes effect immediately. A held result is discarded.

Handshake:
- in_ready = !out_valid | out_ready (combinational).
- Accept occurs when in_valid & in_ready. On the accepting edge, valE/cnd/err are registered and out_valid←1.
- Latency is 1 cycle. Throughput is 1 per cycle while out_ready=1.
- If out_valid & out_ready and no accept on the same edge, out_valid←0.
- When out_valid=1 and out_ready=0, outputs are held stable and no accept occurs.

valE by icode; all arithmetic is modulo 2^WIDTH:
- 2 cmovXX: valA.
- 3 irmovq: valC.
- 4 rmmovq, 5 mrmovq: valB+valC.
- 6 OPq:
  - ifun 0: valB+valA
  - ifun 1: valB−valA
  - ifun 2: valB&valA
  - ifun 3: valB^valA
- 8 call, 10 pushq: valB−STACK_STEP.
- 9 ret, 11 popq: valB+STACK_STEP.
- All other icodes (0 halt, 1 nop, 7 jXX, 12–15): valE=0.

CC update:
- Happens on the accept edge only, for icode 6, valid ifun (0–3), and set_cc_en=1.
- ZF = (result==0).
- SF = result[WIDTH−1].
- OF for add = (valA[MSB]==valB[MSB]) & (result[MSB]!=valB[MSB]).
- OF for sub = (valA[MSB]!=valB[MSB]) & (result[MSB]!=valB[MSB]).
- OF for and/xor = 0.

cnd:
- Evaluated for icode 2 and 7 from the CC register value before the same edge's update.
- ifun 0: 1.
- ifun 1 (le): (SF^OF)|ZF.
- ifun 2 (l): SF^OF.
- ifun 3 (e): ZF.
- ifun 4 (ne): !ZF.
- ifun 5 (ge): !(SF^OF).
- ifun 6 (g): !(SF^OF)&!ZF.
- For all other icodes, cnd=0.

Back-to-back instructions:
- An OPq accepted at edge N followed by jXX/cmov accepted at edge N+1: the second instruction sees the CC written at edge N.

err:
- err=1 when icode 2/7 has ifun>6, or icode 6 has ifun>3.
- In that case valE=0, cnd=0, and CC is unchanged.
- err is registered with the result and cleared on the next accept of a valid instruction.

Idle behaviour:
- While not accepting, cc is stable.
- set_cc_en has no effect on non-OPq instructions.

Test Plan:
- Reset then idle → out_valid=0, cc=3'b100, valE=0; rst asserted mid-hold with out_valid=1 → out_valid=0 immediately, without waiting for a clk edge.
- OPq sub with valB=5, valA=5 → valE=0, cc={1,0,0}. Next cycle jXX ifun 3 → cnd=1. Then jXX ifun 4 → cnd=0.
- OPq add with valB=64'h7FFF_FFFF_FFFF_FFFF, valA=1 → valE=64'h8000_0000_0000_0000, cc={0,1,1}. Next cmovXX ifun 2 with valA=0x55 → cnd=0, valE=0x55.
- pushq valB=0x100 → valE=0xF8; popq valB=0xF8 → valE=0x100; cc unchanged across both.
- Backpressure: hold out_ready=0 with out_valid=1 and in_valid=1 for 3 cycles → in_ready=0, valE stable, no CC change. Release out_ready → the next instruction is accepted on that edge.
- OPq ifun 7 → err=1, valE=0, cc unchanged. OPq add with set_cc_en=0 → valE correct, cc unchanged. Repeat the sub test with WIDTH=16 → identical flag results at bit 15.
